// File: rtl/round_controller_if.sv
// round_controller_if: groups the per-frame game events and the match-control
// outputs of the round sequencer into one bundle.
//
// Signalling: there is no backpressure anywhere on this bundle. hit_valid,
// frame_tick and pause_toggle are single-Clk qualifiers that the controller
// consumes in the cycle they are high (the controller is always ready);
// hit_victim/hit_attacker are meaningful only while hit_valid is high. All
// controller outputs are registered and change only after a Clk edge.
`timescale 1ns/1ps
interface round_controller_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 4,
  parameter int IDW         = 1
);
  // game-side events
  logic                         frame_tick;
  logic                         start;
  logic                         pause_toggle;
  logic                         hit_valid;
  logic [IDW-1:0]               hit_victim;
  logic [IDW-1:0]               hit_attacker;
  logic [NUM_PLAYERS-1:0]       base_hit;

  // match-control outputs
  logic [2:0]                   state;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores;
  logic [NUM_PLAYERS-1:0]       alive;
  logic [NUM_PLAYERS-1:0]       eliminated;
  logic                         freeze;
  logic [7:0]                   countdown;
  logic                         round_reset;
  logic                         winner_valid;
  logic [IDW-1:0]               winner_id;

  // game side: produces events, observes the controller
  modport master (
    output frame_tick, start, pause_toggle, hit_valid, hit_victim,
           hit_attacker, base_hit,
    input  state, scores, alive, eliminated, freeze, countdown,
           round_reset, winner_valid, winner_id
  );

  // controller side
  modport slave (
    input  frame_tick, start, pause_toggle, hit_valid, hit_victim,
           hit_attacker, base_hit,
    output state, scores, alive, eliminated, freeze, countdown,
           round_reset, winner_valid, winner_id
  );
endinterface

// File: rtl/round_controller.sv
// round_controller: N-player match sequencer for the tank game.
// Runs IDLE -> COUNTDOWN -> PLAY <-> PAUSE -> OVER, keeps per-player scores,
// respawn timers and base elimination, and drives freeze/round_reset.
// The FSM state is the public 'state' output, so checkers can bind to it.
`timescale 1ns/1ps
module round_controller #(
  parameter int NUM_PLAYERS      = 2,
  parameter int SCORE_W          = 4,
  parameter int WIN_SCORE        = 5,
  parameter int RESPAWN_FRAMES   = 60,
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int IDW              = (NUM_PLAYERS <= 2) ? 1 : $clog2(NUM_PLAYERS)
) (
  input  logic              Clk,
  input  logic              Reset,
  round_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    PLAY      = 3'd2,
    PAUSE     = 3'd3,
    OVER      = 3'd4
  } state_t;

  localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;
  localparam logic [SCORE_W-1:0] SCORE_WIN   = SCORE_W'(WIN_SCORE);
  localparam logic [7:0]         RESP_LOAD   = 8'(RESPAWN_FRAMES);
  localparam logic [7:0]         CD_LOAD     = 8'(COUNTDOWN_FRAMES);

  // registered state and outputs
  state_t                         state_q;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores_q;
  logic [NUM_PLAYERS-1:0]         alive_q;
  logic [NUM_PLAYERS-1:0]         elim_q;
  logic [NUM_PLAYERS*8-1:0]       resp_q;
  logic                           freeze_q;
  logic [7:0]                     countdown_q;
  logic                           round_reset_q;
  logic                           winner_valid_q;
  logic [IDW-1:0]                 winner_id_q;

  // next values for one PLAY cycle (hits, respawn and base hits merged)
  logic [NUM_PLAYERS*SCORE_W-1:0] play_scores;
  logic [NUM_PLAYERS-1:0]         play_alive;
  logic [NUM_PLAYERS-1:0]         play_elim;
  logic [NUM_PLAYERS*8-1:0]       play_resp;
  logic                           hit_ok;
  logic                           score_win;
  logic [IDW-1:0]                 score_win_id;
  logic                           elim_win;
  logic [IDW-1:0]                 elim_win_id;
  logic [SCORE_W-1:0]             cur_score;
  logic [SCORE_W-1:0]             nxt_score;
  logic [SCORE_W-1:0]             best_score;
  logic [IDW-1:0]                 best_id;
  logic [IDW-1:0]                 last_id;
  int                             remaining;

  // Evaluate the effects of this cycle's events as if the FSM were in PLAY.
  // Acceptance decisions use the registered alive/eliminated flags, so a
  // player respawning this very cycle cannot be hit until the next one.
  always_comb begin
    play_scores  = scores_q;
    play_alive   = alive_q;
    play_elim    = elim_q;
    play_resp    = resp_q;
    hit_ok       = 1'b0;
    score_win    = 1'b0;
    score_win_id = '0;
    elim_win     = 1'b0;
    elim_win_id  = '0;
    cur_score    = '0;
    nxt_score    = '0;
    best_score   = '0;
    best_id      = '0;
    last_id      = '0;
    remaining    = 0;

    // respawn timers run on frame ticks; reaching zero revives the tank
    if (bus.frame_tick) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (resp_q[i*8 +: 8] != 8'd0 && !elim_q[i]) begin
          play_resp[i*8 +: 8] = resp_q[i*8 +: 8] - 8'd1;
          if (resp_q[i*8 +: 8] == 8'd1) play_alive[i] = 1'b1;
        end
      end
    end

    // a hit on a live, in-range victim kills it and reloads its timer;
    // the reload overrides any decrement applied above
    if (bus.hit_valid) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (bus.hit_victim == IDW'(i) && alive_q[i]) begin
          hit_ok              = 1'b1;
          play_alive[i]       = 1'b0;
          play_resp[i*8 +: 8] = RESP_LOAD;
        end
      end
    end

    // the attacker scores unless it shot itself or has lost its base
    if (hit_ok && bus.hit_attacker != bus.hit_victim) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (bus.hit_attacker == IDW'(i) && !elim_q[i]) begin
          cur_score = scores_q[i*SCORE_W +: SCORE_W];
          nxt_score = (cur_score == SCORE_MAX) ? cur_score
                                               : cur_score + SCORE_W'(1);
          play_scores[i*SCORE_W +: SCORE_W] = nxt_score;
          if (nxt_score == SCORE_WIN) begin
            score_win    = 1'b1;
            score_win_id = IDW'(i);
          end
        end
      end
    end

    // base destruction removes the player for the rest of the match
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (bus.base_hit[i]) begin
        play_elim[i]        = 1'b1;
        play_alive[i]       = 1'b0;
        play_resp[i*8 +: 8] = 8'd0;
      end
    end

    // survivors after this cycle's base hits
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (!play_elim[i]) begin
        remaining = remaining + 1;
        last_id   = IDW'(i);
      end
    end

    // fallback winner when nobody survives: highest score, lowest index
    best_score = play_scores[0 +: SCORE_W];
    best_id    = '0;
    for (int i = 1; i < NUM_PLAYERS; i++) begin
      if (play_scores[i*SCORE_W +: SCORE_W] > best_score) begin
        best_score = play_scores[i*SCORE_W +: SCORE_W];
        best_id    = IDW'(i);
      end
    end

    if (remaining == 1) begin
      elim_win    = 1'b1;
      elim_win_id = last_id;
    end else if (remaining == 0) begin
      elim_win    = 1'b1;
      elim_win_id = best_id;
    end
  end

  // Match FSM with all outputs registered alongside the state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= IDLE;
      scores_q       <= '0;
      alive_q        <= '1;
      elim_q         <= '0;
      resp_q         <= '0;
      freeze_q       <= 1'b1;
      countdown_q    <= 8'd0;
      round_reset_q  <= 1'b0;
      winner_valid_q <= 1'b0;
      winner_id_q    <= '0;
    end else begin
      round_reset_q <= 1'b0;
      case (state_q)
        IDLE, OVER: begin
          if (bus.start) begin
            state_q        <= COUNTDOWN;
            countdown_q    <= CD_LOAD;
            round_reset_q  <= 1'b1;
            scores_q       <= '0;
            elim_q         <= '0;
            resp_q         <= '0;
            alive_q        <= '1;
            freeze_q       <= 1'b1;
            winner_valid_q <= 1'b0;
            winner_id_q    <= '0;
          end
        end

        COUNTDOWN: begin
          if (bus.frame_tick) begin
            if (countdown_q == 8'd1) begin
              state_q     <= PLAY;
              countdown_q <= 8'd0;
              freeze_q    <= 1'b0;
            end else begin
              countdown_q <= countdown_q - 8'd1;
            end
          end
        end

        PLAY: begin
          scores_q <= play_scores;
          alive_q  <= play_alive;
          elim_q   <= play_elim;
          resp_q   <= play_resp;
          if (score_win) begin
            state_q        <= OVER;
            freeze_q       <= 1'b1;
            winner_valid_q <= 1'b1;
            winner_id_q    <= score_win_id;
          end else if (elim_win) begin
            state_q        <= OVER;
            freeze_q       <= 1'b1;
            winner_valid_q <= 1'b1;
            winner_id_q    <= elim_win_id;
          end else if (bus.pause_toggle) begin
            state_q  <= PAUSE;
            freeze_q <= 1'b1;
          end
        end

        PAUSE: begin
          if (bus.pause_toggle) begin
            state_q  <= PLAY;
            freeze_q <= 1'b0;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.state        = state_q;
  assign bus.scores       = scores_q;
  assign bus.alive        = alive_q;
  assign bus.eliminated   = elim_q;
  assign bus.freeze       = freeze_q;
  assign bus.countdown    = countdown_q;
  assign bus.round_reset  = round_reset_q;
  assign bus.winner_valid = winner_valid_q;
  assign bus.winner_id    = winner_id_q;

endmodule

// File: tb/tb_round_controller.sv
// tb_round_controller: directed match scenarios plus randomized play for a
// 3-player round_controller, checked cycle by cycle against a behavioural
// match model held in the bench.
`timescale 1ns/1ps
module tb_round_controller;

  localparam int NP   = 3;
  localparam int SW   = 4;
  localparam int WIN  = 5;
  localparam int RESP = 60;
  localparam int CD   = 3;
  localparam int IDW  = 2;
  localparam int EW   = 3 + NP*SW + NP + NP + 1 + 8 + 1 + 1 + IDW;

  localparam int S_IDLE = 0, S_CD = 1, S_PLAY = 2, S_PAUSE = 3, S_OVER = 4;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset;
  always #10 Clk = ~Clk;

  round_controller_if #(.NUM_PLAYERS(NP), .SCORE_W(SW), .IDW(IDW)) bus ();

  round_controller #(
    .NUM_PLAYERS(NP), .SCORE_W(SW), .WIN_SCORE(WIN),
    .RESPAWN_FRAMES(RESP), .COUNTDOWN_FRAMES(CD), .IDW(IDW)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural match model ----------------
  int m_state, m_cd, m_wid;
  bit m_freeze, m_rr, m_wv;
  int m_score[NP];
  int m_resp[NP];
  bit m_alive[NP];
  bit m_elim[NP];

  task automatic model_new_match();
    m_state = S_CD; m_cd = CD; m_rr = 1; m_freeze = 1; m_wv = 0; m_wid = 0;
    for (int i = 0; i < NP; i++) begin
      m_score[i] = 0; m_resp[i] = 0; m_alive[i] = 1; m_elim[i] = 0;
    end
  endtask

  function automatic logic [EW-1:0] pack_exp();
    logic [NP*SW-1:0] sc;
    logic [NP-1:0] al, el;
    for (int i = 0; i < NP; i++) begin
      sc[i*SW +: SW] = SW'(m_score[i]);
      al[i] = m_alive[i];
      el[i] = m_elim[i];
    end
    return {3'(m_state), sc, al, el, m_freeze, 8'(m_cd), m_rr, m_wv, IDW'(m_wid)};
  endfunction

  task automatic model_step(input bit rst, ft, st, pt, hv,
                            input int vic, att, input bit [NP-1:0] bh);
    bit accept, scored;
    int win_id, left, last, best;
    m_rr = 0;
    if (rst) begin
      m_state = S_IDLE; m_cd = 0; m_freeze = 1; m_wv = 0; m_wid = 0;
      for (int i = 0; i < NP; i++) begin
        m_score[i] = 0; m_resp[i] = 0; m_alive[i] = 1; m_elim[i] = 0;
      end
    end else begin
      case (m_state)
        S_IDLE, S_OVER: if (st) model_new_match();
        S_CD: if (ft) begin
          if (m_cd == 1) begin m_state = S_PLAY; m_cd = 0; m_freeze = 0; end
          else m_cd = m_cd - 1;
        end
        S_PLAY: begin
          // decisions use the situation at the start of the frame
          accept = hv && vic < NP && m_alive[vic];
          scored = accept && att != vic && att < NP && !m_elim[att];
          win_id = -1;
          if (ft)
            for (int i = 0; i < NP; i++)
              if (m_resp[i] > 0 && !m_elim[i]) begin
                m_resp[i] = m_resp[i] - 1;
                if (m_resp[i] == 0) m_alive[i] = 1;
              end
          if (accept) begin m_alive[vic] = 0; m_resp[vic] = RESP; end
          if (scored) begin
            m_score[att] = (m_score[att] + 1 > 15) ? 15 : m_score[att] + 1;
            if (m_score[att] == WIN) win_id = att;
          end
          for (int i = 0; i < NP; i++)
            if (bh[i]) begin m_elim[i] = 1; m_alive[i] = 0; m_resp[i] = 0; end
          if (win_id < 0) begin
            left = 0; last = 0;
            for (int i = 0; i < NP; i++) if (!m_elim[i]) begin left++; last = i; end
            if (left == 1) win_id = last;
            else if (left == 0) begin
              best = 0;
              for (int i = 1; i < NP; i++) if (m_score[i] > m_score[best]) best = i;
              win_id = best;
            end
          end
          if (win_id >= 0) begin
            m_state = S_OVER; m_freeze = 1; m_wv = 1; m_wid = win_id;
          end else if (pt) begin
            m_state = S_PAUSE; m_freeze = 1;
          end
        end
        S_PAUSE: if (pt) begin m_state = S_PLAY; m_freeze = 0; end
        default: ;
      endcase
    end
    exp_q.push_back(pack_exp());
  endtask

  // ---------------- compare all outputs against the model ----------------
  task automatic compare_outputs();
    logic [EW-1:0] e;
    e = exp_q.pop_front();
    check_eq("state",        32'(bus.state),        32'(e[33:31]));
    check_eq("scores",       32'(bus.scores),       32'(e[30:19]));
    check_eq("alive",        32'(bus.alive),        32'(e[18:16]));
    check_eq("eliminated",   32'(bus.eliminated),   32'(e[15:13]));
    check_eq("freeze",       32'(bus.freeze),       32'(e[12]));
    check_eq("countdown",    32'(bus.countdown),    32'(e[11:4]));
    check_eq("round_reset",  32'(bus.round_reset),  32'(e[3]));
    check_eq("winner_valid", 32'(bus.winner_valid), 32'(e[2]));
    check_eq("winner_id",    32'(bus.winner_id),    32'(e[1:0]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit rst, ft, st, pt, hv,
                      input int vic, att, input bit [NP-1:0] bh);
    Reset            = rst;
    bus.frame_tick   = ft;
    bus.start        = st;
    bus.pause_toggle = pt;
    bus.hit_valid    = hv;
    bus.hit_victim   = IDW'(vic);
    bus.hit_attacker = IDW'(att);
    bus.base_hit     = bh;
    model_step(rst, ft, st, pt, hv, vic, att, bh);
    @(posedge Clk);
    #1;
    compare_outputs();
  endtask

  task automatic idle(input int n, input bit ft);
    for (int k = 0; k < n; k++) step(0, ft, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic hit(input int vic, input int att);
    step(0, 0, 0, 0, 1, vic, att, '0);
  endtask

  task automatic base(input bit [NP-1:0] bh);
    step(0, 0, 0, 0, 0, 0, 0, bh);
  endtask

  task automatic start_match();
    step(0, 0, 1, 0, 0, 0, 0, '0);
    idle(CD, 1);
  endtask

  function automatic int score_of(input int p);
    return int'(bus.scores[p*SW +: SW]);
  endfunction

  // ---------------- stimulus ----------------
  bit r_rst, r_ft, r_st, r_pt, r_hv;
  int r_vic, r_att;
  bit [NP-1:0] r_bh;

  initial begin
    Reset = 1'b1;
    bus.frame_tick = 0; bus.start = 0; bus.pause_toggle = 0;
    bus.hit_valid = 0; bus.hit_victim = '0; bus.hit_attacker = '0; bus.base_hit = '0;

    // reset state
    step(1, 0, 0, 0, 0, 0, 0, '0);
    step(1, 1, 1, 1, 1, 1, 0, '1);
    check_eq("tp_reset_state", 32'(bus.state), S_IDLE);
    check_eq("tp_reset_alive", 32'(bus.alive), 32'h7);
    idle(3, 1);

    // match start and countdown 3,2,1
    step(0, 0, 1, 0, 0, 0, 0, '0);
    check_eq("tp_round_reset", 32'(bus.round_reset), 1);
    check_eq("tp_cd_load", 32'(bus.countdown), CD);
    idle(1, 0);
    check_eq("tp_round_reset_pulse", 32'(bus.round_reset), 0);
    idle(CD, 1);
    check_eq("tp_play_entry", 32'(bus.state), S_PLAY);
    check_eq("tp_unfreeze", 32'(bus.freeze), 0);

    // hit, respawn after exactly RESP frames, hit on dead victim ignored
    hit(1, 0);
    check_eq("tp_hit_score", score_of(0), 1);
    check_eq("tp_hit_dead", 32'(bus.alive[1]), 0);
    idle(RESP - 1, 1);
    check_eq("tp_still_dead", 32'(bus.alive[1]), 0);
    hit(1, 0);
    check_eq("tp_dead_hit_ignored", score_of(0), 1);
    idle(1, 1);
    check_eq("tp_respawned", 32'(bus.alive[1]), 1);

    // score win on the fifth point
    for (int k = 0; k < 4; k++) begin
      hit(1, 0);
      if (k < 3) idle(RESP, 1);
    end
    check_eq("tp_score_win_state", 32'(bus.state), S_OVER);
    check_eq("tp_score_win_id", 32'(bus.winner_id), 0);
    check_eq("tp_score_win_valid", 32'(bus.winner_valid), 1);
    check_eq("tp_score_win_freeze", 32'(bus.freeze), 1);
    idle(2, 1);

    // pause holds timers and ignores hits
    start_match();
    hit(2, 1);
    idle(10, 1);
    step(0, 0, 0, 1, 0, 0, 0, '0);
    check_eq("tp_paused", 32'(bus.state), S_PAUSE);
    for (int k = 0; k < 20; k++) step(0, 1, 0, 0, 1, 0, 1, '0);
    check_eq("tp_pause_no_score", score_of(1), 1);
    step(0, 0, 0, 1, 0, 0, 0, '0);
    check_eq("tp_resumed", 32'(bus.state), S_PLAY);
    idle(RESP - 11, 1);
    check_eq("tp_pause_held_timer", 32'(bus.alive[2]), 0);
    idle(1, 1);
    check_eq("tp_pause_respawn", 32'(bus.alive[2]), 1);

    // elimination down to one survivor
    base(3'b001);
    check_eq("tp_elim0", 32'(bus.eliminated), 32'h1);
    base(3'b100);
    check_eq("tp_elim_win_state", 32'(bus.state), S_OVER);
    check_eq("tp_elim_win_id", 32'(bus.winner_id), 1);

    // simultaneous wipe-out with scores {2,4,4}: tie goes to player 1
    start_match();
    for (int r = 0; r < 4; r++) begin
      if (r < 2) begin hit(0, 1); hit(1, 2); hit(2, 0); end
      else begin hit(2, 1); hit(0, 2); end
      idle(RESP, 1);
    end
    check_eq("tp_tie_scores", 32'(bus.scores), 32'h442);
    base(3'b111);
    check_eq("tp_tie_state", 32'(bus.state), S_OVER);
    check_eq("tp_tie_winner", 32'(bus.winner_id), 1);

    // reset during pause with nonzero scores
    start_match();
    hit(1, 0);
    step(0, 0, 0, 1, 0, 0, 0, '0);
    step(1, 1, 0, 1, 1, 2, 0, '0);
    check_eq("tp_rst_state", 32'(bus.state), S_IDLE);
    check_eq("tp_rst_scores", 32'(bus.scores), 0);
    check_eq("tp_rst_alive", 32'(bus.alive), 32'h7);
    check_eq("tp_rst_freeze", 32'(bus.freeze), 1);
    idle(2, 0);

    // randomized play
    for (int c = 0; c < 4000; c++) begin
      r_rst = ($urandom_range(0, 599) == 0);
      r_ft  = 1'($urandom_range(0, 1));
      r_st  = ($urandom_range(0, 15) == 0);
      r_hv  = ($urandom_range(0, 9) < 3);
      r_vic = $urandom_range(0, 3);
      r_att = $urandom_range(0, 3);
      r_bh  = '0;
      r_pt  = 0;
      if (!r_hv) begin
        if ($urandom_range(0, 39) == 0) r_bh = NP'(1 << $urandom_range(0, NP-1));
        else if ($urandom_range(0, 24) == 0) r_pt = 1;
      end
      step(r_rst, r_ft, r_st, r_pt, r_hv, r_vic, r_att, r_bh);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
